// File: rtl/fir_sample_window_pkg.sv
// fir_sample_window_pkg: shared constants for the FIR sample-ingest delay line.
// Holds the default geometry and the handshake state encoding.
package fir_sample_window_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NUM_REGS   = 8;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    HOLD   = 2'd1,
    STEADY = 2'd2
  } state_t;

endpackage

// File: rtl/fir_sample_window_tap_shift_reg.sv
// tap_shift_reg: parameterised delay line with shift enable and synchronous clear.
// Tap 0 (least significant slice) holds the newest sample.
module tap_shift_reg #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           clr,
  input  logic [DATA_WIDTH-1:0]          din,
  output logic [NUM_REGS*DATA_WIDTH-1:0] taps
);

  // Shift a new sample into tap 0 and drop the oldest; clear wins over shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps <= '0;
    end else if (clr) begin
      taps <= '0;
    end else if (en) begin
      taps <= {taps[(NUM_REGS-1)*DATA_WIDTH-1:0], din};
    end
  end

endmodule

// File: rtl/fir_sample_window.sv
// fir_sample_window: sample-ingest delay line that presents each complete tap
// window exactly once to the MAC over a valid/ready handshake.
// Optional feature macro FIR_ZERO_PREFILL_EN: when defined, taps count as
// zero-prefilled and every accepted sample presents a window.
module fir_sample_window
  import fir_sample_window_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [DATA_WIDTH-1:0]            s_data,
  input  logic                             flush,
  output logic                             win_valid,
  input  logic                             win_ready,
  output logic [NUM_REGS*DATA_WIDTH-1:0]   win_data,
  output logic [$clog2(NUM_REGS+1)-1:0]    fill_count
);

  localparam int            CW         = $clog2(NUM_REGS + 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(NUM_REGS);
  localparam logic [CW-1:0] COUNT_LAST = CW'(NUM_REGS - 1);

  state_t state;
  logic   accept;
  logic   completes_window;

  // A held window blocks new samples unless the MAC takes it this very cycle,
  // which lets accept and consume overlap with no bubble.
  assign s_ready = (state != HOLD) || win_ready;
  assign accept  = s_valid && s_ready && !flush;

`ifdef FIR_ZERO_PREFILL_EN
  assign completes_window = 1'b1;
`else
  assign completes_window = (fill_count == COUNT_LAST);
`endif

  tap_shift_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_taps (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .clr  (flush),
    .din  (s_data),
    .taps (win_data)
  );

  // Handshake FSM with registered win_valid and saturating fill counter; flush overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      win_valid  <= 1'b0;
      fill_count <= '0;
    end else if (flush) begin
      state      <= FILL;
      win_valid  <= 1'b0;
      fill_count <= '0;
    end else begin
      if (accept && (fill_count != COUNT_FULL)) begin
        fill_count <= fill_count + 1'b1;
      end
      case (state)
        FILL: begin
          if (accept && completes_window) begin
            state     <= HOLD;
            win_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (win_ready && !s_valid) begin
            state     <= STEADY;
            win_valid <= 1'b0;
          end
        end
        STEADY: begin
          if (accept) begin
            state     <= HOLD;
            win_valid <= 1'b1;
          end
        end
        default: begin
          state     <= FILL;
          win_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sample_window.sv
// tb_fir_sample_window: directed, table-driven checks of fir_sample_window
// with NUM_REGS=4, DATA_WIDTH=16. Honours FIR_ZERO_PREFILL_EN if defined.
module tb_fir_sample_window;

  localparam int DW = 16;
  localparam int NR = 4;
  localparam int CW = $clog2(NR + 1);
`ifdef FIR_ZERO_PREFILL_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = NR;
`endif

  typedef struct {
    logic           sv;
    logic           wr;
    logic           fl;
    logic [DW-1:0]  d;
    logic           exp_sr;
    logic           exp_wv;
    logic [NR*DW-1:0] exp_win;
    logic [CW-1:0]  exp_fill;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [DW-1:0]     s_data;
  logic              flush;
  logic              win_valid;
  logic              win_ready;
  logic [NR*DW-1:0]  win_data;
  logic [CW-1:0]     fill_count;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[$];

  fir_sample_window #(
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .flush      (flush),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_data   (win_data),
    .fill_count (fill_count)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  function automatic logic [NR*DW-1:0] win4(int t0, int t1, int t2, int t3);
    return {DW'(t3), DW'(t2), DW'(t1), DW'(t0)};
  endfunction

  function automatic vec_t mk(logic sv, logic wr, logic fl, int d, logic sr,
                              logic wv, logic [NR*DW-1:0] w, int f);
    vec_t v;
    v.sv = sv; v.wr = wr; v.fl = fl; v.d = DW'(d);
    v.exp_sr = sr; v.exp_wv = wv; v.exp_win = w; v.exp_fill = CW'(f);
    return v;
  endfunction

  task automatic checkVal(string name, logic [NR*DW-1:0] act, logic [NR*DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(string name, logic wv, logic [NR*DW-1:0] w, logic [CW-1:0] f);
    checkVal({name, "_win_valid"}, win_valid, wv);
    checkVal({name, "_win_data"}, win_data, w);
    checkVal({name, "_fill_count"}, fill_count, f);
  endtask

  task automatic applyStimulus(logic sv, logic wr, logic fl, int d);
    s_valid   = sv;
    win_ready = wr;
    flush     = fl;
    s_data    = DW'(d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int consumed;
    int next_exp;
    logic [NR*DW-1:0] e;

    rst = 1'b1;
    applyStimulus(0, 0, 0, 0);
    #12;
    checkVal("reset_s_ready", s_ready, 1);
    checkOutput("reset", 0, '0, 0);
    rst = 1'b0;
    tick();

`ifdef FIR_ZERO_PREFILL_EN
    vecs.push_back(mk(1, 0, 0, 7, 1, 1, win4(7, 0, 0, 0), 1));
    vecs.push_back(mk(1, 0, 0, 8, 0, 1, win4(7, 0, 0, 0), 1));
    vecs.push_back(mk(1, 1, 0, 8, 1, 1, win4(8, 7, 0, 0), 2));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, win4(8, 7, 0, 0), 2));
    vecs.push_back(mk(1, 0, 0, 9, 1, 1, win4(9, 8, 7, 0), 3));
    vecs.push_back(mk(1, 1, 1, 5, 1, 0, '0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, '0, 0));
    vecs.push_back(mk(1, 0, 0, 3, 1, 1, win4(3, 0, 0, 0), 1));
`else
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, win4(1, 0, 0, 0), 1));
    vecs.push_back(mk(1, 0, 0, 2, 1, 0, win4(2, 1, 0, 0), 2));
    vecs.push_back(mk(1, 0, 0, 3, 1, 0, win4(3, 2, 1, 0), 3));
    vecs.push_back(mk(1, 0, 0, 4, 1, 1, win4(4, 3, 2, 1), 4));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 0, 0, 5, 0, 1, win4(4, 3, 2, 1), 4));
    vecs.push_back(mk(1, 1, 0, 5, 1, 1, win4(5, 4, 3, 2), 4));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, win4(5, 4, 3, 2), 4));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, win4(5, 4, 3, 2), 4));
    vecs.push_back(mk(1, 0, 0, 6, 1, 1, win4(6, 5, 4, 3), 4));
    vecs.push_back(mk(1, 1, 1, 7, 1, 0, '0, 0));
    vecs.push_back(mk(1, 1, 0, 8, 1, 0, win4(8, 0, 0, 0), 1));
    vecs.push_back(mk(1, 1, 0, 9, 1, 0, win4(9, 8, 0, 0), 2));
    vecs.push_back(mk(1, 1, 0, 10, 1, 0, win4(10, 9, 8, 0), 3));
    vecs.push_back(mk(1, 1, 0, 11, 1, 1, win4(11, 10, 9, 8), 4));
    vecs.push_back(mk(1, 1, 0, 12, 1, 1, win4(12, 11, 10, 9), 4));
    vecs.push_back(mk(1, 0, 1, 13, 0, 0, '0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, '0, 0));
`endif

    $display("[TB] table: %0d vectors", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].sv, vecs[i].wr, vecs[i].fl, vecs[i].d);
      #1;
      checkVal($sformatf("row%0d_s_ready", i), s_ready, vecs[i].exp_sr);
      tick();
      checkOutput($sformatf("row%0d", i), vecs[i].exp_wv, vecs[i].exp_win, vecs[i].exp_fill);
    end

    $display("[TB] async reset while holding a window");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= NR; k++) begin
      applyStimulus(1, 0, 0, k);
      tick();
    end
    checkVal("prereset_win_valid", win_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    checkVal("midhold_reset_s_ready", s_ready, 1);
    checkOutput("midhold_reset", 0, '0, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    rst = 1'b0;
    tick();

    $display("[TB] streaming 1..10");
    consumed = 0;
    next_exp = FIRST;
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1, 1, 0, k);
      #1;
      checkVal($sformatf("stream%0d_s_ready", k), s_ready, 1);
      if (win_valid && win_ready) begin
        consumed++;
        checkVal($sformatf("stream%0d_consumed_tap0", k), win_data[DW-1:0], DW'(next_exp));
        next_exp++;
      end
      tick();
      e = '0;
      for (int t = 0; t < NR; t++)
        if (k - t > 0) e[t*DW +: DW] = DW'(k - t);
      checkOutput($sformatf("stream%0d", k), (k >= FIRST), e, (k < NR) ? k : NR);
    end
    applyStimulus(0, 1, 0, 0);
    #1;
    if (win_valid && win_ready) begin
      consumed++;
      checkVal("stream_last_consumed_tap0", win_data[DW-1:0], DW'(next_exp));
    end
    tick();
    checkVal("stream_windows_consumed", consumed, 11 - FIRST);
    checkVal("stream_end_win_valid", win_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
